// File: rtl/payload_eng_pkg.sv
// Shared types and defaults for the payload match engine scheduler.
package payload_eng_pkg;

    // Scheduler phases: clear the bank, stream bytes, flush the chains, hand off.
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        REPORT
    } state_t;

    // Width of the per-packet byte counter and of r_len.
    localparam int LEN_W = 16;

    // Bank geometry used by the engine bank generator.
    localparam int N_ENG_DEF     = 32;
    localparam int IDX_W_DEF     = 5;
    localparam int MAX_LEN_DEF   = 1500;
    localparam int DRAIN_CYC_DEF = 3;

endpackage

// File: rtl/payload_match_prienc.sv
// Lowest-index priority encoder over the sampled engine match vector.
module payload_match_prienc
    import payload_eng_pkg::*;
#(
    parameter int N_ENG = N_ENG_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [N_ENG-1:0] match,
    output logic [IDX_W-1:0] first,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        first = '0;
        any   = 1'b0;
        for (int i = N_ENG - 1; i >= 0; i--) begin
            if (match[i]) begin
                first = IDX_W'(i);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/payload_engine_sched.sv
// Sequences one bank of payload match engines over a packet byte stream:
// clear at start of packet, pace bytes in, drain the chains, report once.
//
// Handshakes: a byte moves on any rising edge where s_valid & s_ready are
// both high; s_ready may depend on s_valid/s_sop (a start-of-packet byte is
// refused until the bank has been cleared, so the upstream simply holds it).
// A result moves on any rising edge where r_valid & r_ready are both high;
// r_valid never depends on r_ready and all r_* fields hold while r_valid=1.
module payload_engine_sched
    import payload_eng_pkg::*;
#(
    parameter int N_ENG     = N_ENG_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int MAX_LEN   = MAX_LEN_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_sop,
    input  logic             s_eop,
    output logic             s_ready,
    output logic [7:0]       eng_data,
    output logic             eng_char_vld,
    output logic             eng_en,
    output logic             eng_sod,
    input  logic [N_ENG-1:0] eng_match,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [N_ENG-1:0] r_match,
    output logic             r_any,
    output logic [IDX_W-1:0] r_first,
    output logic [LEN_W-1:0] r_len,
    output logic             r_trunc,
    output logic             r_err,
    output logic [31:0]      stat_pkts,
    output logic [31:0]      stat_drop
);

    localparam int             CNT_W     = $clog2(DRAIN_CYC + 1);
    localparam logic [LEN_W:0] MAX_LEN_X = (LEN_W + 1)'(MAX_LEN);

    state_t            state, state_nx;
    logic              live;
    logic              sod_q;
    logic              feed_q;
    logic [LEN_W-1:0]  len;
    logic              trunc, err;
    logic [CNT_W-1:0]  dcnt;
    logic              accept, feed, sop_abort, drain_done;
    logic [IDX_W-1:0]  first_c;
    logic              any_c;

    assign accept     = s_valid & s_ready;
    // Only the first MAX_LEN bytes reach the engines; later ones are counted only.
    assign feed       = (state == STREAM) & accept & ({1'b0, len} < MAX_LEN_X);
    // A sop inside an open packet aborts it; the sop byte itself stays upstream.
    assign sop_abort  = (state == STREAM) & s_valid & s_sop & (len != '0);
    // Count 0 is the cycle carrying the last byte; counts 1..DRAIN_CYC are nulls.
    assign drain_done = (state == DRAIN) & (dcnt == CNT_W'(DRAIN_CYC));

    assign eng_sod      = sod_q;
    assign eng_char_vld = feed_q;

    payload_match_prienc #(
        .N_ENG (N_ENG),
        .IDX_W (IDX_W)
    ) u_prienc (
        .match (eng_match),
        .first (first_c),
        .any   (any_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (live && s_valid && s_sop) state_nx = CLEAR;
            CLEAR:   state_nx = STREAM;
            STREAM:  if (sop_abort || (accept && s_eop)) state_nx = DRAIN;
            DRAIN:   if (drain_done) state_nx = REPORT;
            REPORT:  if (r_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Per-state handshake and engine enable outputs.
    always_comb begin
        s_ready = 1'b0;
        eng_en  = feed_q;
        r_valid = 1'b0;
        case (state)
            IDLE:    s_ready = live & ~(s_valid & s_sop);
            STREAM:  s_ready = ~(s_valid & s_sop & (len != '0));
            DRAIN:   eng_en  = feed_q | (dcnt != '0);
            REPORT:  r_valid = 1'b1;
            default: ;
        endcase
    end

    // Control flops: ready gate after reset, clear pulse, registered byte strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live     <= 1'b0;
            sod_q    <= 1'b1;
            feed_q   <= 1'b0;
            eng_data <= '0;
        end else begin
            live   <= 1'b1;
            sod_q  <= (state_nx == CLEAR);
            feed_q <= feed;
            if (feed) eng_data <= s_data;
        end
    end

    // Per-packet length, truncate/abort flags and drain counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len   <= '0;
            trunc <= 1'b0;
            err   <= 1'b0;
            dcnt  <= '0;
        end else begin
            if (state == CLEAR) begin
                len   <= '0;
                trunc <= 1'b0;
                err   <= 1'b0;
            end else begin
                if ((state == STREAM) && accept && (len != '1)) len <= len + 1'b1;
                if ((state == STREAM) && accept && !feed) trunc <= 1'b1;
                if (sop_abort) err <= 1'b1;
            end
            if (state != DRAIN)   dcnt <= '0;
            else if (!drain_done) dcnt <= dcnt + 1'b1;
        end
    end

    // Result record, captured on the edge that closes the drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match <= '0;
            r_first <= '0;
            r_any   <= 1'b0;
            r_len   <= '0;
            r_trunc <= 1'b0;
            r_err   <= 1'b0;
        end else if (drain_done) begin
            r_match <= eng_match;
            r_first <= first_c;
            r_any   <= any_c;
            r_len   <= len;
            r_trunc <= trunc;
            r_err   <= err;
        end
    end

    // Statistics: results handed off and bytes dropped outside a packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkts <= '0;
            stat_drop <= '0;
        end else begin
            if (r_valid && r_ready)          stat_pkts <= stat_pkts + 32'd1;
            if ((state == IDLE) && accept)   stat_drop <= stat_drop + 32'd1;
        end
    end

endmodule

// File: tb/tb_payload_engine_sched.sv
// Bench for payload_engine_sched: a small sticky engine bank model, random
// packet traffic, and a scoreboard fed from a behavioural packet model.
module tb_payload_engine_sched;

    localparam int N_ENG     = 32;
    localparam int IDX_W     = 5;
    localparam int MAX_LEN   = 20;
    localparam int DRAIN_CYC = 3;
    localparam int LATENCY   = DRAIN_CYC + 2;
    localparam int NPKT      = 40;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       s_data = '0;
    logic             s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0;
    logic             s_ready;
    logic [7:0]       eng_data;
    logic             eng_char_vld, eng_en, eng_sod;
    logic [N_ENG-1:0] eng_match = '0;
    logic             r_valid;
    logic             r_ready = 1'b0;
    logic [N_ENG-1:0] r_match;
    logic             r_any;
    logic [IDX_W-1:0] r_first;
    logic [15:0]      r_len;
    logic             r_trunc, r_err;
    logic [31:0]      stat_pkts, stat_drop;

    typedef struct packed {
        logic [N_ENG-1:0] match;
        logic [IDX_W-1:0] first;
        logic             any;
        logic [15:0]      len;
        logic             trunc;
        logic             err;
        logic [15:0]      nfed;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  pkt_q[$];
    logic [7:0]  trig[N_ENG];
    int          checks = 0;
    int          errors = 0;
    int          exp_pkts = 0;
    int          exp_drop = 0;
    int          overlap = 0;
    bit          hold_ready = 1'b0;

    payload_engine_sched #(
        .N_ENG(N_ENG), .IDX_W(IDX_W), .MAX_LEN(MAX_LEN), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop), .s_ready(s_ready),
        .eng_data(eng_data), .eng_char_vld(eng_char_vld), .eng_en(eng_en), .eng_sod(eng_sod),
        .eng_match(eng_match),
        .r_valid(r_valid), .r_ready(r_ready), .r_match(r_match), .r_any(r_any),
        .r_first(r_first), .r_len(r_len), .r_trunc(r_trunc), .r_err(r_err),
        .stat_pkts(stat_pkts), .stat_drop(stat_drop)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Engine k fires on byte trig[k]; engine 31 fires on '&'.
    initial begin
        for (int k = 0; k < N_ENG; k++) trig[k] = (k == N_ENG - 1) ? 8'h26 : 8'(8'h80 + k);
    end

    // Engine bank model: one chain stage then a sticky end state, CE on eng_en.
    logic [N_ENG-1:0] chain_q = '0;
    always @(posedge clk) begin
        if (eng_sod) begin
            chain_q   <= '0;
            eng_match <= '0;
        end else if (eng_en) begin
            for (int k = 0; k < N_ENG; k++)
                chain_q[k] <= eng_char_vld && (eng_data == trig[k]);
            eng_match <= eng_match | chain_q;
        end
    end

    // ---------------- reference model ----------------
    function automatic exp_t ref_result(input bit aborted);
        exp_t e;
        int   n;
        int   nfed;
        bit   found;
        e     = '0;
        n     = pkt_q.size();
        nfed  = (n < MAX_LEN) ? n : MAX_LEN;
        found = 1'b0;
        for (int i = 0; i < nfed; i++)
            for (int k = 0; k < N_ENG; k++)
                if (pkt_q[i] == trig[k]) e.match[k] = 1'b1;
        for (int k = 0; k < N_ENG; k++)
            if (e.match[k] && !found) begin
                e.first = IDX_W'(k);
                found   = 1'b1;
            end
        e.any   = found;
        e.len   = (n > 65535) ? 16'hFFFF : 16'(n);
        e.trunc = (n > MAX_LEN);
        e.err   = aborted;
        e.nfed  = 16'(nfed);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put_byte(input logic [7:0] d, input logic sop, input logic eop);
        int budget;
        bit ok;
        budget  = 500;
        ok      = 1'b0;
        s_data  = d;
        s_sop   = sop;
        s_eop   = eop;
        s_valid = 1'b1;
        while (budget > 0 && !ok) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            budget--;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
        s_data  = 8'($urandom_range(0, 255));
        chk("byte_accept", 64'(ok), 64'd1);
    endtask

    task automatic gen_packet(input int n);
        pkt_q.delete();
        for (int i = 0; i < n; i++)
            pkt_q.push_back(($urandom_range(0, 3) == 0) ? trig[$urandom_range(0, N_ENG - 1)]
                                                         : 8'($urandom_range(0, 255)));
    endtask

    task automatic send_packet(input bit with_eop, input bit push, input bit gaps);
        int n;
        n = pkt_q.size();
        for (int i = 0; i < n; i++) begin
            put_byte(pkt_q[i], i == 0, with_eop && (i == n - 1));
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        if (push) exp_q.push_back(ref_result(!with_eop));
    endtask

    task automatic wait_drained();
        int budget;
        budget = 600;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        chk("drain_wait_pending", 64'(exp_q.size()), 64'd0);
        idle(1);
    endtask

    task automatic send_drops(input int n);
        for (int i = 0; i < n; i++) begin
            put_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
            exp_drop++;
        end
    endtask

    // Result consumer: random back-pressure unless a stall is being forced.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            r_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          fed_cnt = 0, en_cnt = 0, fed_seen = 0, en_seen = 0, lat_cnt = 0;
    bit          lat_on = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
    logic [63:0] snap = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            fed_cnt    = 0;
            en_cnt     = 0;
            lat_on     = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (eng_sod && eng_en) overlap++;
            if (eng_sod) begin
                fed_cnt = 0;
                en_cnt  = 0;
            end else begin
                if (eng_char_vld) fed_cnt++;
                if (eng_en)       en_cnt++;
            end
            if (lat_on) lat_cnt++;
            if (r_valid && !prev_valid) begin
                fed_seen = fed_cnt;
                en_seen  = en_cnt;
                if (lat_on) chk("eop_to_rvalid_latency", 64'(lat_cnt), 64'(LATENCY));
                lat_on = 1'b0;
                chk("report_sready_low", 64'(s_ready), 64'd0);
            end
            if (s_valid && s_ready && s_eop) begin
                lat_on  = 1'b1;
                lat_cnt = 0;
            end
            if (r_valid && prev_valid && !prev_ready) begin
                chk("stall_fields_stable", {8'd0, r_match, r_first, r_any, r_len, r_trunc, r_err}, snap);
                chk("stall_no_sod", 64'(eng_sod), 64'd0);
                chk("stall_sready_low", 64'(s_ready), 64'd0);
            end
            if (r_valid && r_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("r_match",  64'(r_match), 64'(e.match));
                    chk("r_first",  64'(r_first), 64'(e.first));
                    chk("r_any",    64'(r_any),   64'(e.any));
                    chk("r_len",    64'(r_len),   64'(e.len));
                    chk("r_trunc",  64'(r_trunc), 64'(e.trunc));
                    chk("r_err",    64'(r_err),   64'(e.err));
                    chk("char_vld_cycles", 64'(fed_seen), 64'(e.nfed));
                    chk("eng_en_cycles",   64'(en_seen),  64'(e.nfed) + 64'(DRAIN_CYC));
                    exp_pkts++;
                end
            end
            prev_valid = r_valid;
            prev_ready = r_ready;
            snap       = {8'd0, r_match, r_first, r_any, r_len, r_trunc, r_err};
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        string golf;
        int    seen_valid;
        int    budget;
        bit    prev_abort;
        golf = "POST /golfstream&";

        // Reset values.
        idle(3);
        chk("rst_s_ready",   64'(s_ready),   64'd0);
        chk("rst_eng_sod",   64'(eng_sod),   64'd1);
        chk("rst_eng_en",    64'(eng_en),    64'd0);
        chk("rst_char_vld",  64'(eng_char_vld), 64'd0);
        chk("rst_r_valid",   64'(r_valid),   64'd0);
        chk("rst_r_fields",  {8'd0, r_match, r_first, r_any, r_len, r_trunc, r_err}, 64'd0);
        chk("rst_stat_pkts", 64'(stat_pkts), 64'd0);
        chk("rst_stat_drop", 64'(stat_drop), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Directed packet: the trailing '&' lights engine 31.
        pkt_q.delete();
        for (int i = 0; i < golf.len(); i++) pkt_q.push_back(golf[i]);
        send_packet(1'b1, 1'b1, 1'b0);
        wait_drained();
        chk("stat_pkts_after_golf", 64'(stat_pkts), 64'(exp_pkts));

        // Same packet with the consumer stalled for 10 cycles after r_valid.
        hold_ready = 1'b1;
        send_packet(1'b1, 1'b1, 1'b0);
        budget = 200;
        while (!r_valid && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        idle(10);
        chk("stall_rvalid_held",     64'(r_valid),   64'd1);
        chk("stall_stat_pkts_frozen", 64'(stat_pkts), 64'(exp_pkts));
        hold_ready = 1'b0;
        wait_drained();
        chk("stat_pkts_after_stall", 64'(stat_pkts), 64'(exp_pkts));

        // Abort: a new sop on byte 4 of an open packet, then a normal packet.
        gen_packet(4);
        send_packet(1'b0, 1'b1, 1'b0);
        gen_packet(6);
        send_packet(1'b1, 1'b1, 1'b0);
        wait_drained();

        // Random traffic with gaps, truncation, aborts and dropped bytes.
        prev_abort = 1'b0;
        for (int p = 0; p < NPKT; p++) begin
            bit ab;
            ab = (p < NPKT - 1) && ($urandom_range(0, 7) == 0);
            if (!prev_abort && $urandom_range(0, 5) == 0) begin
                wait_drained();
                send_drops($urandom_range(1, 3));
            end
            gen_packet($urandom_range(1, 30));
            send_packet(!ab, 1'b1, 1'b1);
            prev_abort = ab;
        end
        wait_drained();
        chk("stat_pkts_random", 64'(stat_pkts), 64'(exp_pkts));
        chk("stat_drop_random", 64'(stat_drop), 64'(exp_drop));

        // Reset while draining: nothing may be reported for that packet.
        gen_packet(9);
        send_packet(1'b1, 1'b0, 1'b0);
        idle(1);
        rst_n = 1'b0;
        #1;
        exp_pkts = 0;
        exp_drop = 0;
        chk("mid_rst_eng_sod",   64'(eng_sod),   64'd1);
        chk("mid_rst_eng_en",    64'(eng_en),    64'd0);
        chk("mid_rst_s_ready",   64'(s_ready),   64'd0);
        chk("mid_rst_r_valid",   64'(r_valid),   64'd0);
        chk("mid_rst_stat_pkts", 64'(stat_pkts), 64'd0);
        chk("mid_rst_r_fields",  {8'd0, r_match, r_first, r_any, r_len, r_trunc, r_err}, 64'd0);
        idle(3);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r_valid) seen_valid++;
        end
        idle(1);
        chk("no_result_after_reset", 64'(seen_valid), 64'd0);

        // Three stray bytes, then a 1-byte packet of a non-matching 'A'.
        send_drops(3);
        pkt_q.delete();
        pkt_q.push_back(8'h41);
        send_packet(1'b1, 1'b1, 1'b0);
        wait_drained();
        chk("stat_drop_three", 64'(stat_drop), 64'd3);

        // One more random packet to show recovery is complete.
        gen_packet(15);
        send_packet(1'b1, 1'b1, 1'b1);
        wait_drained();
        chk("final_stat_pkts", 64'(stat_pkts), 64'(exp_pkts));
        chk("final_stat_drop", 64'(stat_drop), 64'(exp_drop));
        chk("sod_en_overlap",  64'(overlap),   64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
